// File: rtl/furv_bus_pkg.sv
// Purpose: shared definitions for the FURV data-bus bridge (FSM state codes, timer width, request record).
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package furv_bus_pkg;

    // Width of the Wishbone termination timeout down-counter.
    localparam int TMR_W = 16;

    // Bridge FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Latched core request; every Wishbone request field is driven from this.
    typedef struct packed {
        logic        we;
        logic [29:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wb_req_t;

endpackage

// File: rtl/furv_bus_timer.sv
// Purpose: loadable down-counter that bounds how long a Wishbone access may wait for termination.
// Latency: load and decrement take effect on the next clk edge; zero is combinational from the count.
// Backpressure: none; en simply freezes the count.
// Ports: clk/rst (async active-high), load + load_val (reload, wins over en),
//        en (decrement by one), zero (count is 0).
module furv_bus_timer
    import furv_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/furv_dbus_bridge.sv
// Purpose: bridges the FURV core data-access handshake onto a Wishbone classic master port.
// Latency: 3 cycles per access (IDLE accept, >=1 BUS, RESP) with a slave that acks in the first BUS cycle.
// Backpressure: core holds core_mem until core_ack; slave stalls by withholding ack, bounded by TIMEOUT.
// Ports: core_* request/response from the core; wb_*_o master request, wb_*_i slave response;
//        bus_error sticky error/timeout flag, cleared by err_clear (a same-cycle set wins).
module furv_dbus_bridge
    import furv_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_mem,
    input  logic        core_we,
    input  logic [29:0] core_addr,
    input  logic [3:0]  core_sel,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_ack,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [29:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        bus_error,
    input  logic        err_clear
);

    logic [1:0] state;
    wb_req_t    req_q;
    logic       in_bus;
    logic       tmr_zero;
    logic       term_ok;
    logic       term_err;

    assign in_bus = (state == ST_BUS);

    // Error beats ack; a timeout only counts when no ack arrives in the same cycle.
    assign term_err = in_bus && (wb_err_i || (tmr_zero && !wb_ack_i));
    assign term_ok  = in_bus && wb_ack_i && !wb_err_i;

    // The timer reaches zero in BUS cycle TIMEOUT+1, so the abort lands there.
    furv_bus_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == ST_IDLE) && core_mem),
        .load_val (TMR_W'(TIMEOUT)),
        .en       (in_bus && !wb_ack_i && !wb_err_i && !tmr_zero),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            core_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (core_mem) begin
                        req_q <= '{we: core_we, adr: core_addr, sel: core_sel, dat: core_wdata};
                        state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (term_ok || term_err) begin
                        core_rdata <= (term_ok && !req_q.we) ? wb_dat_i : '0;
                        state      <= ST_RESP;
                    end
                end
                // Always pass through IDLE so a held core_mem cannot restart here.
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_error <= 1'b0;
        end else if (term_err) begin
            bus_error <= 1'b1;
        end else if (err_clear) begin
            bus_error <= 1'b0;
        end
    end

    // Strobes decode straight from the async-reset state register, so rst drops them at once.
    assign wb_cyc_o = in_bus;
    assign wb_stb_o = in_bus;
    assign wb_we_o  = req_q.we;
    assign wb_adr_o = req_q.adr;
    assign wb_sel_o = req_q.sel;
    assign wb_dat_o = req_q.dat;
    assign core_ack = (state == ST_RESP);

endmodule

// File: tb/tb_furv_dbus_bridge.sv
// Purpose: scoreboard bench for furv_dbus_bridge; directed accesses push expected responses,
//          a monitor pops and compares on every core_ack.
// Latency/backpressure: driven by a scripted Wishbone slave with programmable wait states.
module tb_furv_dbus_bridge;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared core request fields; each bridge has its own core_mem / err_clear.
    logic        core_mem, core_mem_t;
    logic        core_we;
    logic [29:0] core_addr;
    logic [3:0]  core_sel;
    logic [31:0] core_wdata;
    logic        err_clear, err_clear_t;

    logic [31:0] core_rdata, core_rdata_t;
    logic        core_ack, core_ack_t;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic        wb_cyc_t, wb_stb_t, wb_we_t;
    logic [29:0] wb_adr_o, wb_adr_t;
    logic [3:0]  wb_sel_o, wb_sel_t;
    logic [31:0] wb_dat_o, wb_dat_t;
    logic        bus_error, bus_error_t;

    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i;

    // Main bridge with default TIMEOUT, driven by the scripted slave.
    furv_dbus_bridge dut (
        .clk(clk), .rst(rst),
        .core_mem(core_mem), .core_we(core_we), .core_addr(core_addr),
        .core_sel(core_sel), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_ack(core_ack),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .bus_error(bus_error), .err_clear(err_clear)
    );

    // Short-timeout bridge facing a slave that never answers.
    furv_dbus_bridge #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst),
        .core_mem(core_mem_t), .core_we(core_we), .core_addr(core_addr),
        .core_sel(core_sel), .core_wdata(core_wdata),
        .core_rdata(core_rdata_t), .core_ack(core_ack_t),
        .wb_cyc_o(wb_cyc_t), .wb_stb_o(wb_stb_t), .wb_we_o(wb_we_t),
        .wb_adr_o(wb_adr_t), .wb_sel_o(wb_sel_t), .wb_dat_o(wb_dat_t),
        .wb_dat_i(32'hFFFF_FFFF), .wb_ack_i(1'b0), .wb_err_i(1'b0),
        .bus_error(bus_error_t), .err_clear(err_clear_t)
    );

    int n_vec = 0;
    int n_bad = 0;
    exp_t q_main[$];
    exp_t q_t[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scripted slave: terminates in BUS cycle slv_wait+1 with the programmed ack/err/data.
    int          slv_wait = 0;
    logic        slv_ack = 1'b1;
    logic        slv_err = 1'b0;
    logic [31:0] slv_dat = '0;
    int          bus_cnt = 0;

    always @(negedge clk) begin
        if (wb_stb_o) begin
            if (bus_cnt == slv_wait) begin
                wb_ack_i = slv_ack;
                wb_err_i = slv_err;
                wb_dat_i = slv_dat;
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = 32'h5A5A_5A5A;
            end
            bus_cnt = bus_cnt + 1;
        end else begin
            bus_cnt  = 0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = 32'h5A5A_5A5A;
        end
    end

    // Monitor: every core_ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && core_ack) begin
            if (q_main.size() == 0) begin
                check("unexpected_ack_main", 32'd1, 32'd0);
            end else begin
                e = q_main.pop_front();
                check("ack_rdata_main", core_rdata, e.rdata);
                check("ack_buserr_main", 32'(bus_error), 32'(e.err));
            end
        end
        if (!rst && core_ack_t) begin
            if (q_t.size() == 0) begin
                check("unexpected_ack_t", 32'd1, 32'd0);
            end else begin
                e = q_t.pop_front();
                check("ack_rdata_t", core_rdata_t, e.rdata);
                check("ack_buserr_t", 32'(bus_error_t), 32'(e.err));
            end
        end
    end

    // Issue one access at #1 after a posedge, wait (bounded) for core_ack, and report
    // the edges taken, BUS cycles seen, and whether the wb fields stayed as issued.
    task automatic run_req(input logic t, input logic hold, input logic we, input logic [29:0] a,
                           input logic [3:0] s, input logic [31:0] wd,
                           output int cycles, output int bus_cycles, output logic stable);
        logic got;
        core_we = we; core_addr = a; core_sel = s; core_wdata = wd;
        if (t) core_mem_t = 1'b1; else core_mem = 1'b1;
        cycles = 0; bus_cycles = 0; stable = 1'b1; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (t ? wb_stb_t : wb_stb_o) begin
                bus_cycles++;
                if (t ? (wb_cyc_t !== 1'b1 || wb_we_t !== we || wb_adr_t !== a || wb_sel_t !== s || wb_dat_t !== wd)
                      : (wb_cyc_o !== 1'b1 || wb_we_o !== we || wb_adr_o !== a || wb_sel_o !== s || wb_dat_o !== wd))
                    stable = 1'b0;
            end
            if (t ? core_ack_t : core_ack) got = 1'b1;
        end
        if (!got) check("ack_wait_bound", 32'd0, 32'd1);
        if (!hold) begin
            core_mem = 1'b0;
            core_mem_t = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   cyc, bcyc;
        logic stab;

        rst = 1'b1;
        core_mem = 0; core_mem_t = 0; core_we = 0; core_addr = '0; core_sel = '0;
        core_wdata = '0; err_clear = 0; err_clear_t = 0;
        wb_ack_i = 0; wb_err_i = 0; wb_dat_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_ack", 32'(core_ack), 32'd0);
        check("rst_rdata", core_rdata, 32'd0);
        check("rst_buserr", 32'(bus_error), 32'd0);
        check("rst_fields", {wb_we_o, wb_adr_o, wb_sel_o} == '0 && wb_dat_o == '0 ? 32'd1 : 32'd0, 32'd1);
        check("rst_cyc_t", 32'(wb_cyc_t), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_no_cyc", 32'(wb_cyc_o), 32'd0);

        // Load, immediate ack
        slv_wait = 0; slv_ack = 1; slv_err = 0; slv_dat = 32'hDEAD_BEEF;
        q_main.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
        run_req(0, 0, 0, 30'h000_0010, 4'hF, 32'h0, cyc, bcyc, stab);
        check("load_latency", 32'(cyc), 32'd2);
        check("load_bus_cycles", 32'(bcyc), 32'd1);
        check("load_fields", 32'(stab), 32'd1);
        @(posedge clk); #1;
        check("rdata_hold_idle", core_rdata, 32'hDEAD_BEEF);

        // Store, ack after 5 wait states
        slv_wait = 5; slv_dat = 32'hCAFE_F00D;
        q_main.push_back('{rdata: 32'h0, err: 1'b0});
        run_req(0, 0, 1, 30'h3FFF_FFFF, 4'b0100, 32'h00AB_0000, cyc, bcyc, stab);
        check("store_bus_cycles", 32'(bcyc), 32'd6);
        check("store_fields_stable", 32'(stab), 32'd1);
        check("store_latency", 32'(cyc), 32'd7);
        @(posedge clk); #1;

        // TIMEOUT=4, silent slave
        q_t.push_back('{rdata: 32'h0, err: 1'b1});
        run_req(1, 0, 0, 30'h000_0055, 4'hF, 32'h0, cyc, bcyc, stab);
        check("tmo_bus_cycles", 32'(bcyc), 32'd5);
        check("tmo_latency", 32'(cyc), 32'd6);
        @(posedge clk); #1;
        check("tmo_err_sticky", 32'(bus_error_t), 32'd1);
        err_clear_t = 1'b1;
        @(posedge clk); #1;
        err_clear_t = 1'b0;
        check("tmo_err_cleared", 32'(bus_error_t), 32'd0);

        // ack and err together, with err_clear held: error wins, set beats clear
        slv_wait = 2; slv_ack = 1; slv_err = 1; slv_dat = 32'h1111_2222;
        err_clear = 1'b1;
        q_main.push_back('{rdata: 32'h0, err: 1'b1});
        run_req(0, 0, 0, 30'h000_0020, 4'b0011, 32'h0, cyc, bcyc, stab);
        err_clear = 1'b0;
        check("both_bus_cycles", 32'(bcyc), 32'd3);
        @(posedge clk); #1;
        check("both_err_sticky", 32'(bus_error), 32'd1);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        check("both_err_cleared", 32'(bus_error), 32'd0);

        // Back-to-back with core_mem held: second request must pass through IDLE first
        slv_wait = 0; slv_ack = 1; slv_err = 0; slv_dat = 32'h0BAD_F00D;
        q_main.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
        q_main.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
        run_req(0, 1, 0, 30'h000_0100, 4'hF, 32'h0, cyc, bcyc, stab);
        check("b2b_first_latency", 32'(cyc), 32'd2);
        run_req(0, 0, 0, 30'h000_0200, 4'hF, 32'h0, cyc, bcyc, stab);
        check("b2b_second_latency", 32'(cyc), 32'd3);
        check("b2b_second_fields", 32'(stab), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_no_duplicate", 32'(wb_cyc_o), 32'd0);

        // Reset in the middle of BUS
        slv_wait = 20;
        core_we = 0; core_addr = 30'h000_0077; core_sel = 4'hF; core_wdata = '0;
        core_mem = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_bus_cyc", 32'(wb_cyc_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_async_adr", 32'(wb_adr_o), 32'd0);
        check("rst_async_rdata", core_rdata, 32'd0);
        core_mem = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        slv_wait = 0; slv_dat = 32'hDEAD_BEEF;
        q_main.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
        run_req(0, 0, 0, 30'h000_0010, 4'hF, 32'h0, cyc, bcyc, stab);
        check("post_rst_latency", 32'(cyc), 32'd2);

        repeat (5) @(posedge clk);
        #1;
        check("missing_acks_main", 32'(q_main.size()), 32'd0);
        check("missing_acks_t", 32'(q_t.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/furv_dbus_bridge.md
FURV_DBUS_BRIDGE -- requirements
Module: furv_dbus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles wb_stb_o waits for a termination before the bridge aborts the transfer (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port core_mem, input, 1, core data-access request; held with its qualifiers until core_ack.
REQ-005 SHALL have port core_we, input, 1, request is a store.
REQ-006 SHALL have port core_addr, input, 30, word address.
REQ-007 SHALL have port core_sel, input, 4, byte lane enables.
REQ-008 SHALL have port core_wdata, input, 32, lane-aligned store data.
REQ-009 SHALL have port core_rdata, output, 32, load data returned to the core.
REQ-010 SHALL have port core_ack, output, 1, one-cycle completion strobe to the core.
REQ-011 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o (output, 1 each), wb_adr_o (output, 30), wb_sel_o (output, 4), wb_dat_o (output, 32), forming the Wishbone classic master request.
REQ-012 SHALL have ports wb_dat_i (input, 32), wb_ack_i (input, 1), wb_err_i (input, 1), forming the Wishbone slave response.
REQ-013 SHALL have port bus_error, output, 1, sticky flag: an access ended in error or timeout.
REQ-014 SHALL have port err_clear, input, 1, synchronous clear of bus_error.

Function
REQ-015 SHALL implement states IDLE, BUS, RESP.
REQ-016 IDLE: when core_mem=1, SHALL latch core_we/addr/sel/wdata into registers, load timer with TIMEOUT, and go to BUS; all wb outputs are driven from these registers.
REQ-017 BUS: wb_cyc_o=wb_stb_o=1 throughout; request fields SHALL be constant for the whole state.
REQ-018 BUS: on wb_ack_i=1, SHALL capture wb_dat_i into core_rdata (loads only; stores give 0) and go to RESP.
REQ-019 BUS: on wb_err_i=1, or the timer reaching 0 with no ack, SHALL set core_rdata=0, set bus_error, and go to RESP.
REQ-020 If wb_ack_i and wb_err_i are both 1 in the same cycle, error SHALL take priority.
REQ-021 Timer SHALL decrement once per BUS cycle without termination; with TIMEOUT=N the abort occurs in the (N+1)th BUS cycle if no termination has arrived by then.
REQ-022 RESP: core_ack=1 for exactly this one cycle, wb_cyc_o=wb_stb_o=0, then SHALL go to IDLE unconditionally.
REQ-023 IDLE SHALL not be left in the same cycle RESP exits; a new request is accepted at the earliest in the cycle after RESP.
REQ-024 Latency: with a slave that acks in the first BUS cycle, core_ack rises 2 cycles after core_mem is first seen, i.e. 3 cycles per access.
REQ-025 core_mem=0 in IDLE SHALL keep all wb strobes low; core_mem dropping during BUS SHALL NOT abort the transfer.
REQ-026 core_rdata SHALL hold its last value outside RESP.
REQ-027 err_clear SHALL clear bus_error unless a set occurs in the same cycle; set wins.

Reset
REQ-028 On rst=1, SHALL immediately enter IDLE and drive core_ack=0, core_rdata=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_sel_o=0, wb_dat_o=0, bus_error=0, timer=0.
REQ-029 Reset during BUS SHALL drop wb_cyc_o asynchronously, and the abandoned transfer SHALL NOT produce core_ack.

Structure
REQ-030 State encoding and the timer width constant (16) SHALL live in shared package furv_bus_pkg.
REQ-031 The timeout down-counter SHALL be a sub-module furv_bus_timer (load, enable, zero flag).

Verification
REQ-032 Load, addr=0x0000010, sel=1111, slave acks in 1st BUS cycle with 0xDEADBEEF -> core_ack in cycle 2, core_rdata=0xDEADBEEF, bus_error=0.
REQ-033 Store, addr=0x3FFFFFFF, sel=0100, wdata=0x00AB0000, slave acks after 5 wait cycles -> wb fields stable for 6 BUS cycles, wb_we_o=1, one core_ack.
REQ-034 TIMEOUT=4, no slave response -> stb dropped after 5 BUS cycles, core_ack=1 with rdata=0, bus_error=1; err_clear -> bus_error=0.
REQ-035 wb_ack_i and wb_err_i both 1 -> rdata=0, bus_error=1.
REQ-036 Back-to-back requests (core_mem held) -> second wb_cyc_o rises one cycle after the first core_ack, no duplicate transfer.
REQ-037 rst asserted mid-BUS -> wb_cyc_o=0 without clock edge, no core_ack, next request behaves as REQ-032.
